// File: rtl/vta_fetch_dispatch.sv
// vta_fetch_dispatch: classifies fetched VTA instructions into load, compute
// and store queues, with in-order valid/ready back-pressure, a sticky
// invalid-instruction flag and per-queue occupancy.
// Optional build macro: VTA_DISPATCH_BYPASS_EN (empty-queue same-cycle bypass).
module vta_fetch_dispatch #(
  parameter int INST_W      = 128,
  parameter int ALU_OP_LSB  = 108,
  parameter int NUM_ALU_OPS = 4,
  parameter int DEPTH       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_inst_valid,
  output logic                       io_inst_ready,
  input  logic [INST_W-1:0]          io_inst_bits,
  output logic                       io_ld_valid,
  output logic                       io_co_valid,
  output logic                       io_st_valid,
  input  logic                       io_ld_ready,
  input  logic                       io_co_ready,
  input  logic                       io_st_ready,
  output logic [INST_W-1:0]          io_ld_bits,
  output logic [INST_W-1:0]          io_co_bits,
  output logic [INST_W-1:0]          io_st_bits,
  output logic [$clog2(DEPTH):0]     io_ld_count,
  output logic [$clog2(DEPTH):0]     io_co_count,
  output logic [$clog2(DEPTH):0]     io_st_count,
  output logic                       io_err_invalid,
  input  logic                       io_err_clear,
  output logic                       io_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    NOPS    = 4'(NUM_ALU_OPS);

  typedef enum logic [1:0] {
    CLS_LD  = 2'd0,
    CLS_CO  = 2'd1,
    CLS_ST  = 2'd2,
    CLS_INV = 2'd3
  } cls_e;

  cls_e                cls;
  logic [2:0]          op, mem, alu;
  logic                accept;
  logic                target_space;
  logic [2:0]          cons_ready, hit, byp, push, pop, q_valid;
  logic [INST_W-1:0]   store [3][DEPTH];
  logic [PW-1:0]       rptr  [3];
  logic [PW-1:0]       wptr  [3];
  logic [CW-1:0]       cnt   [3];
  logic [INST_W-1:0]   head  [3];
  logic                err_q;

  assign op  = io_inst_bits[2:0];
  assign mem = io_inst_bits[9:7];
  assign alu = io_inst_bits[ALU_OP_LSB+2:ALU_OP_LSB];

  // Combinational instruction classification
  always_comb begin
    cls = CLS_INV;
    case (op)
      3'd0:       cls = (mem == 3'd1 || mem == 3'd2) ? CLS_LD : CLS_CO;
      3'd1:       cls = CLS_ST;
      3'd2, 3'd3: cls = CLS_CO;
      3'd4:       cls = ({1'b0, alu} < NOPS) ? CLS_CO : CLS_INV;
      default:    cls = CLS_INV;
    endcase
  end

  // Ready depends only on the target queue's current occupancy
  always_comb begin
    target_space = 1'b1;
    case (cls)
      CLS_LD:  target_space = cnt[0] < DEPTH_C;
      CLS_CO:  target_space = cnt[1] < DEPTH_C;
      CLS_ST:  target_space = cnt[2] < DEPTH_C;
      default: target_space = 1'b1;
    endcase
  end

  assign io_inst_ready = (cls == CLS_INV) | target_space;
  assign accept        = io_inst_valid & io_inst_ready;
  assign cons_ready    = {io_st_ready, io_co_ready, io_ld_ready};
  assign hit           = {accept & (cls == CLS_ST),
                          accept & (cls == CLS_CO),
                          accept & (cls == CLS_LD)};

  // Per-queue push/pop and head selection
  always_comb begin
    byp = '0;
    for (int unsigned q = 0; q < 3; q++) begin
`ifdef VTA_DISPATCH_BYPASS_EN
      byp[q] = hit[q] & (cnt[q] == '0) & cons_ready[q];
`else
      byp[q] = 1'b0;
`endif
    end
    push = hit & ~byp;
    for (int unsigned q = 0; q < 3; q++) begin
      pop[q]     = (cnt[q] != '0) & cons_ready[q];
      q_valid[q] = (cnt[q] != '0) | byp[q];
      head[q]    = byp[q] ? io_inst_bits : store[q][rptr[q]];
    end
  end

  // Queue storage, pointers and occupancy counters
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned q = 0; q < 3; q++) begin
        for (int unsigned i = 0; i < DEPTH; i++) store[q][i] <= '0;
        rptr[q] <= '0;
        wptr[q] <= '0;
        cnt[q]  <= '0;
      end
    end else begin
      for (int unsigned q = 0; q < 3; q++) begin
        if (push[q]) begin
          store[q][wptr[q]] <= io_inst_bits;
          wptr[q]           <= wptr[q] + PW'(1);
        end
        if (pop[q]) rptr[q] <= rptr[q] + PW'(1);
        case ({push[q], pop[q]})
          2'b10:   cnt[q] <= cnt[q] + CW'(1);
          2'b01:   cnt[q] <= cnt[q] - CW'(1);
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

  // Sticky invalid flag; a same-cycle invalid accept beats a clear
  always_ff @(posedge clock) begin
    if (reset)                        err_q <= 1'b0;
    else if (accept && cls == CLS_INV) err_q <= 1'b1;
    else if (io_err_clear)            err_q <= 1'b0;
  end

  assign io_ld_valid    = q_valid[0];
  assign io_co_valid    = q_valid[1];
  assign io_st_valid    = q_valid[2];
  assign io_ld_bits     = head[0];
  assign io_co_bits     = head[1];
  assign io_st_bits     = head[2];
  assign io_ld_count    = cnt[0];
  assign io_co_count    = cnt[1];
  assign io_st_count    = cnt[2];
  assign io_err_invalid = err_q;
  assign io_busy        = |q_valid;

endmodule

// File: tb/tb_vta_fetch_dispatch.sv
// Self-checking bench for vta_fetch_dispatch (default build, DEPTH=4).
module tb_vta_fetch_dispatch;

  localparam int W     = 128;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_inst_valid = 1'b0;
  logic          io_inst_ready;
  logic [W-1:0]  io_inst_bits = '0;
  logic          io_ld_valid, io_co_valid, io_st_valid;
  logic          io_ld_ready = 1'b1, io_co_ready = 1'b1, io_st_ready = 1'b1;
  logic [W-1:0]  io_ld_bits, io_co_bits, io_st_bits;
  logic [2:0]    io_ld_count, io_co_count, io_st_count;
  logic          io_err_invalid;
  logic          io_err_clear = 1'b0;
  logic          io_busy;

  vta_fetch_dispatch #(.INST_W(W), .ALU_OP_LSB(108), .NUM_ALU_OPS(4), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_inst_valid(io_inst_valid), .io_inst_ready(io_inst_ready), .io_inst_bits(io_inst_bits),
    .io_ld_valid(io_ld_valid), .io_co_valid(io_co_valid), .io_st_valid(io_st_valid),
    .io_ld_ready(io_ld_ready), .io_co_ready(io_co_ready), .io_st_ready(io_st_ready),
    .io_ld_bits(io_ld_bits), .io_co_bits(io_co_bits), .io_st_bits(io_st_bits),
    .io_ld_count(io_ld_count), .io_co_count(io_co_count), .io_st_count(io_st_count),
    .io_err_invalid(io_err_invalid), .io_err_clear(io_err_clear), .io_busy(io_busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  // Model state: one queue per class, the sticky flag, consumption logs
  logic [W-1:0] m_ld[$], m_co[$], m_st[$];
  logic [W-1:0] ld_log[$], co_log[$], st_log[$];
  logic [W-1:0] fetch[$];
  bit           m_err = 1'b0;
  bit           m_acc = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0=LD 1=CO 2=ST 3=INVALID, straight from the decode rules
  function automatic int dec(input logic [W-1:0] w);
    int op  = int'(w[2:0]);
    int mem = int'(w[9:7]);
    int alu = int'(w[110:108]);
    if (op == 0) return (mem == 1 || mem == 2) ? 0 : 1;
    if (op == 1) return 2;
    if (op == 2 || op == 3) return 1;
    if (op == 4 && alu < 4) return 1;
    return 3;
  endfunction

  function automatic bit m_ready(input int c);
    case (c)
      0: return m_ld.size() < DEPTH;
      1: return m_co.size() < DEPTH;
      2: return m_st.size() < DEPTH;
      default: return 1'b1;
    endcase
  endfunction

  // Model update at each active edge from the inputs the DUT also sees
  always @(posedge clock) begin
    int  c;
    bit  rdy;
    logic [W-1:0] w;
    if (reset) begin
      m_ld.delete(); m_co.delete(); m_st.delete();
      m_err = 1'b0;
      m_acc = 1'b0;
    end else begin
      c     = dec(io_inst_bits);
      rdy   = m_ready(c);
      m_acc = io_inst_valid && rdy;
      if (m_ld.size() != 0 && io_ld_ready) begin w = m_ld.pop_front(); ld_log.push_back(w); end
      if (m_co.size() != 0 && io_co_ready) begin w = m_co.pop_front(); co_log.push_back(w); end
      if (m_st.size() != 0 && io_st_ready) begin w = m_st.pop_front(); st_log.push_back(w); end
      if (m_acc) begin
        case (c)
          0: m_ld.push_back(io_inst_bits);
          1: m_co.push_back(io_inst_bits);
          2: m_st.push_back(io_inst_bits);
          default: ;
        endcase
      end
      if (m_acc && c == 3) m_err = 1'b1;
      else if (io_err_clear) m_err = 1'b0;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("inst_ready", W'(io_inst_ready), W'(m_ready(dec(io_inst_bits))));
      chk("ld_valid", W'(io_ld_valid), W'(m_ld.size() != 0));
      chk("co_valid", W'(io_co_valid), W'(m_co.size() != 0));
      chk("st_valid", W'(io_st_valid), W'(m_st.size() != 0));
      if (m_ld.size() != 0) chk("ld_bits", io_ld_bits, m_ld[0]);
      if (m_co.size() != 0) chk("co_bits", io_co_bits, m_co[0]);
      if (m_st.size() != 0) chk("st_bits", io_st_bits, m_st[0]);
      chk("ld_count", W'(io_ld_count), W'(m_ld.size()));
      chk("co_count", W'(io_co_count), W'(m_co.size()));
      chk("st_count", W'(io_st_count), W'(m_st.size()));
      chk("err", W'(io_err_invalid), W'(m_err));
      chk("busy", W'(io_busy), W'(m_ld.size() != 0 || m_co.size() != 0 || m_st.size() != 0));
    end
  end

  // One clock: advance the in-order fetch stream past an accepted word
  task automatic step();
    @(posedge clock);
    #2;
    if (m_acc && fetch.size() != 0) fetch.delete(0);
    io_inst_valid = fetch.size() != 0;
    io_inst_bits  = (fetch.size() != 0) ? fetch[0] : '0;
  endtask

  task automatic chk_log(input string n, input logic [W-1:0] got[$], input logic [W-1:0] exp[$]);
    chk({n, "_len"}, W'(got.size()), W'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(n, (i < got.size()) ? got[i] : 'x, exp[i]);
  endtask

  task automatic clear_logs();
    ld_log.delete(); co_log.delete(); st_log.delete();
  endtask

  logic [W-1:0] e_ld[$], e_co[$], e_st[$], none[$];
  logic [W-1:0] w_alu2, w_alu3, w_alu5;

  initial begin
    w_alu2 = W'(4) | (W'(2) << 108);
    w_alu3 = W'(4) | (W'(3) << 108);
    w_alu5 = W'(4) | (W'(5) << 108);
    none.delete();

    // Reset state; any word is acceptable right after reset
    reset = 1'b1; io_inst_bits = W'(128'h80);
    step(); step();
    chk("rst_ld_valid", W'(io_ld_valid), '0);
    chk("rst_counts", W'({io_ld_count, io_co_count, io_st_count}), '0);
    chk("rst_bits", io_ld_bits | io_co_bits | io_st_bits, '0);
    chk("rst_busy", W'(io_busy), '0);
    chk("rst_inst_ready", W'(io_inst_ready), W'(1));
    reset = 1'b0;
    cmp_en = 1'b1;

    // Back-to-back mixed stream, all consumers ready
    clear_logs();
    fetch = '{W'(128'h80), W'(128'h100), W'(0), W'(128'h180), W'(1), W'(2), W'(3), w_alu2};
    step();
    step();
    chk("lat1_ld_valid", W'(io_ld_valid), W'(1));
    chk("lat1_ld_bits", io_ld_bits, W'(128'h80));
    repeat (12) step();
    e_ld = '{W'(128'h80), W'(128'h100)};
    e_co = '{W'(0), W'(128'h180), W'(2), W'(3), w_alu2};
    e_st = '{W'(1)};
    chk_log("t1_ld", ld_log, e_ld);
    chk_log("t1_co", co_log, e_co);
    chk_log("t1_st", st_log, e_st);

    // Invalid drops plus the alu boundary (3 legal, 5 illegal)
    clear_logs();
    fetch = '{w_alu5, W'(5), W'(7), w_alu3};
    step();
    repeat (6) step();
    chk("t2_err", W'(io_err_invalid), W'(1));
    chk_log("t2_ld", ld_log, none);
    chk_log("t2_st", st_log, none);
    e_co = '{w_alu3};
    chk_log("t2_co", co_log, e_co);
    io_err_clear = 1'b1; step(); io_err_clear = 1'b0;
    chk("t2_err_cleared", W'(io_err_invalid), '0);
    fetch = '{W'(6)};
    io_err_clear = 1'b1; step(); step(); io_err_clear = 1'b0;
    chk("t2_set_beats_clear", W'(io_err_invalid), W'(1));
    io_err_clear = 1'b1; step(); io_err_clear = 1'b0;
    chk("t2_err_cleared2", W'(io_err_invalid), '0);

    // Back-pressure on a full LD queue blocks a younger compute word
    clear_logs();
    io_ld_ready = 1'b0;
    fetch = '{W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80), W'(2)};
    step();
    repeat (8) step();
    chk("t3_full_count", W'(io_ld_count), W'(4));
    chk("t3_full_ready", W'(io_inst_ready), '0);
    chk("t3_co_blocked", W'(io_co_count), '0);
    io_ld_ready = 1'b1;
    step();
    chk("t3_pop_no_push", W'(io_ld_count), W'(3));
    chk("t3_ready_after_pop", W'(io_inst_ready), W'(1));
    step();
    chk("t3_push_pop", W'(io_ld_count), W'(3));
    repeat (10) step();
    e_ld = '{W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80), W'(128'h80)};
    e_co = '{W'(2)};
    chk_log("t3_ld", ld_log, e_ld);
    chk_log("t3_co", co_log, e_co);

    // Wrap-around with ten distinct store words
    clear_logs();
    e_st.delete();
    for (int i = 0; i < 10; i++) begin
      fetch.push_back(W'(1) | (W'(i + 1) << 16) | (W'(i) << 120));
      e_st.push_back(W'(1) | (W'(i + 1) << 16) | (W'(i) << 120));
    end
    step();
    repeat (14) step();
    chk_log("t5_st", st_log, e_st);
    chk("t5_count", W'(io_st_count), '0);

    // Mid-operation reset with three CO entries and the flag set
    clear_logs();
    io_co_ready = 1'b0;
    fetch = '{W'(7), W'(2), W'(3), W'(128'h180)};
    step();
    repeat (6) step();
    chk("t6_pre_count", W'(io_co_count), W'(3));
    chk("t6_pre_err", W'(io_err_invalid), W'(1));
    reset = 1'b1;
    fetch.delete();
    io_inst_valid = 1'b0;
    step();
    chk("t6_co_valid", W'(io_co_valid), '0);
    chk("t6_co_count", W'(io_co_count), '0);
    chk("t6_err", W'(io_err_invalid), '0);
    chk("t6_busy", W'(io_busy), '0);
    chk("t6_co_bits", io_co_bits, '0);
    reset = 1'b0;
    io_co_ready = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
